// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port bundle: pipeline WB, long-latency unit results, commit port, stall info.
// Pure wiring; no latency of its own.
// Backpressure on the LU side only, via lu_ready; WB side has none.
interface regfile_write_arbiter_if;
  logic        init_req;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        busy;
  logic [31:0] pend_mask;

  // Pipeline / LU side drives requests and observes the commit port.
  modport master (
    output init_req, wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    input  lu_ready, regwrite, write_reg, write_data, busy, pend_mask
  );

  // Arbiter side.
  modport slave (
    input  init_req, wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    output lu_ready, regwrite, write_reg, write_data, busy, pend_mask
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: WB (fixed priority) vs buffered LU results, plus an init sweep.
// Latency: 1 cycle from sampled request to registered write port.
// Backpressure: lu_ready low when FIFO full or not in RUN; WB never stalls, busy tells pipeline to stall.
module regfile_write_arbiter #(
  parameter int          NUM_REGS   = 32,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] INIT_VALUE = 32'h0
) (
  input logic clk,
  input logic rst,
  regfile_write_arbiter_if.slave rf
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [4:0]    LAST_IDX = 5'(NUM_REGS - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic          regwrite_q, regwrite_d;
  logic [4:0]    write_reg_q, write_reg_d;
  logic [31:0]   write_data_q, write_data_d;

  logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] occ_q [32];
  logic [31:0]   pend_mask_w;

  logic          lu_ready_w;
  logic          push;
  logic          pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  // Full check uses the current count, so a full FIFO refuses even when popping this edge.
  assign lu_ready_w = (state_q == S_RUN) && (count_q < DEPTH_C);
  assign push       = rf.lu_valid && lu_ready_w;
  assign head_rd    = fifo_rd_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  // State register for the INIT/RUN/DRAIN controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state and write-port selection: sweep in INIT, WB over FIFO head otherwise; x0 writes are dropped.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    pop          = 1'b0;
    case (state_q)
      S_INIT: begin
        regwrite_d   = 1'b1;
        write_reg_d  = idx_q;
        write_data_d = INIT_VALUE;
        idx_d        = idx_q + 5'd1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN, S_DRAIN: begin
        if (rf.wb_valid) begin
          write_reg_d  = rf.wb_rd;
          write_data_d = rf.wb_data;
          regwrite_d   = (rf.wb_rd != 5'd0);
        end else if (count_q != '0) begin
          pop          = 1'b1;
          write_reg_d  = head_rd;
          write_data_d = head_data;
          regwrite_d   = (head_rd != 5'd0);
        end
        if (state_q == S_RUN && rf.init_req) begin
          state_d = S_DRAIN;
        end else if (state_q == S_DRAIN && count_q == '0) begin
          state_d = S_INIT;
          idx_d   = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // FIFO pointers and occupancy; reset discards any buffered LU results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  // FIFO storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= rf.lu_rd;
      fifo_data_q[wr_ptr_q] <= rf.lu_data;
    end
  end

  // Per-register count of buffered LU writes, so duplicates keep the pending bit until the last one commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) occ_q[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if ((push && rf.lu_rd == 5'(r)) && !(pop && head_rd == 5'(r)))
          occ_q[r] <= occ_q[r] + CW'(1);
        else if (!(push && rf.lu_rd == 5'(r)) && (pop && head_rd == 5'(r)))
          occ_q[r] <= occ_q[r] - CW'(1);
      end
      occ_q[0] <= '0;
    end
  end

  // Pending mask is just "occupancy non-zero" per register.
  always_comb begin
    pend_mask_w = '0;
    for (int r = 0; r < 32; r++) pend_mask_w[r] = (occ_q[r] != '0);
  end

  assign rf.lu_ready   = lu_ready_w;
  assign rf.regwrite   = regwrite_q;
  assign rf.write_reg  = write_reg_q;
  assign rf.write_data = write_data_q;
  assign rf.busy       = (state_q != S_RUN);
  assign rf.pend_mask  = pend_mask_w;

endmodule
